tx_ack_sequencer: RTL

Transaction controller that sequences one transmitter→receiver exchange. It accepts a transmit request and waits a fixed start delay. It then counts non-consecutive receiver acknowledges until a programmed number have arrived, and pulses complete on the following cycle. It sits between the transmit requester and the receiver handshake. By construction it satisfies `transmitter |-> ##START_DELAY receiver[->ACK_COUNT] ##1 complete`, with a timeout and abort path added.

---
 rtl/tx_ack_pkg.sv | 8 +
 rtl/tx_ack_sequencer.sv | 84 ++++++++
 2 files changed

// File: rtl/tx_ack_pkg.sv
// tx_ack_pkg: shared state encoding and default timing for tx_ack_sequencer
package tx_ack_pkg;
  typedef enum logic [2:0] {IDLE, DELAY, WAIT_ACK, DONE, ERR} tx_ack_state_e;
  localparam int TX_START_DELAY = 2;
  localparam int TX_ACK_COUNT   = 2;
  localparam int TX_TIMEOUT     = 16;
  localparam int TX_CNT_W       = 4;
endpackage

// File: rtl/tx_ack_sequencer.sv
// tx_ack_sequencer: request -> fixed delay -> N acknowledges -> complete pulse, with timeout and abort
module tx_ack_sequencer
  import tx_ack_pkg::*;
#(
  parameter int START_DELAY = TX_START_DELAY,
  parameter int ACK_COUNT   = TX_ACK_COUNT,
  parameter int TIMEOUT     = TX_TIMEOUT,
  parameter int CNT_W       = TX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             transmitter,
  input  logic             receiver,
  input  logic             abort,
  output logic             complete,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] ack_cnt
);
  localparam int DW = START_DELAY > 1 ? $clog2(START_DELAY) : 1;
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  tx_ack_state_e    state;
  logic [DW-1:0]    dly_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] ack_inc;
  logic             final_ack;
  logic             tmo_hit;
  assign ack_inc   = ack_cnt + CNT_W'(1);
  assign final_ack = receiver && (ack_inc == CNT_W'(ACK_COUNT));
  assign tmo_hit   = (TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      complete    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ack_cnt     <= '0;
      dly_cnt     <= '0;
      wait_cnt    <= '0;
    end else begin
      complete    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (transmitter) begin
          ack_cnt  <= '0;
          wait_cnt <= '0;
          dly_cnt  <= DW'(START_DELAY - 1);
          state    <= START_DELAY == 1 ? WAIT_ACK : DELAY;
          busy     <= 1'b1;
        end
        DELAY: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          dly_cnt <= dly_cnt - DW'(1);
          if (dly_cnt == DW'(1)) state <= WAIT_ACK;
        end
        WAIT_ACK: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + WW'(1);
          if (receiver) ack_cnt <= ack_inc;
          // the final acknowledge beats a timeout landing on the same edge
          if (final_ack) begin
            state    <= DONE;
            complete <= 1'b1;
          end else if (tmo_hit) begin
            state       <= ERR;
            timeout_err <= 1'b1;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
